mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory controller directly downstream of the core's memory port.
- Accepts one read or one write request at a time and drives a single-port synchronous SRAM (1-cycle read latency, per-byte write enables).
- Handles byte/half/word writes and arbitrary byte addresses: an access that crosses a word boundary is split into two SRAM word accesses.
- Flags out-of-range addresses and illegal widths with o_fault.

Parameters:
- DATA_WIDTH, 32, bus/SRAM word width in bits; only 32 supported.
- MEM_WORDS, 1024, SRAM depth in words; ADDR_W = $clog2(MEM_WORDS) derived locally.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_addr  in  32  byte address of request; little-endian.
- i_wr_data  in  DATA_WIDTH  write data, low bytes significant.
- i_wr_valid  in  1  write request.
- o_wr_ready  out  1  write complete, one-cycle pulse.
- i_wr_width  in  3  write size in bytes: 3'b001, 3'b010 or 3'b100.
- o_rd_data  out  DATA_WIDTH  4 bytes starting at latched address.
- o_rd_valid  out  1  read data valid.
- i_rd_ready  in  1  read request / consumer ready.
- o_fault  out  1  qualifies the current response as faulted.
- o_mem_en  out  1  SRAM access enable.
- o_mem_we  out  DATA_WIDTH/8  SRAM byte write enables; all zero means read.
- o_mem_addr  out  ADDR_W  SRAM word index.
- o_mem_wdata  out  DATA_WIDTH  SRAM write data, byte-lane aligned.
- i_mem_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after o_mem_en with o_mem_we = 0.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; every output 0; latched request cleared. Reset mid-operation abandons the access, including a pending second write half.
- States: IDLE, RD_A, RD_B, RD_RESP, WR_B, WR_ACK.
- Accept (IDLE only):
  - Latch i_addr, i_wr_data and i_wr_width.
  - i_wr_valid has priority over i_rd_ready when both are high.
  - Word A = i_addr[31:2]; the access spans A+1 when (i_addr[1:0] + size) > 4. Read size is always 4.
- Fault check at accept:
  - Any touched word index ≥ MEM_WORDS, or a write width not in {1,2,4}, sets fault.
  - Word A+1 that overflows 2^30 is faulted; the index does not wrap.
  - Faulted access: no SRAM activity. Read goes to RD_RESP with o_rd_data=0. Write goes to WR_ACK. o_fault=1 alongside the response.
- Read path:
  - IDLE accept: issue read A, go to RD_A.
  - RD_A: capture i_mem_rdata. If split, issue read A+1 and go to RD_B; else go to RD_RESP.
  - RD_B: capture the second word, go to RD_RESP.
  - Merge: o_rd_data = bytes off..off+3 of the concatenation {word(A+1), word(A)}, where off = addr[1:0].
  - RD_RESP: o_rd_valid=1 and o_rd_data held stable until i_rd_ready=1 on a clock edge, then IDLE.
  - Latency from accept to o_rd_valid: 2 cycles unsplit, 3 cycles split.
- Write path:
  - Accept cycle: write word A. o_mem_we = the size-byte mask shifted left by off, truncated to 4 bits. o_mem_wdata = i_wr_data << 8*off.
  - If split: go to WR_B and write word A+1 with the remaining bytes (mask shifted right by 4-off, data >> 8*(4-off)), then WR_ACK. Otherwise go straight to WR_ACK.
  - WR_ACK: o_wr_ready=1 for exactly one cycle, then IDLE.
- Request handling:
  - Requester holds its request until the response. A request still asserted in the IDLE cycle after completion is a new request.
  - Changes to inputs after accept are ignored.
- SRAM outputs: o_mem_en, o_mem_we and o_mem_addr are combinational from state and latched/incoming request. o_mem_we=0 whenever o_mem_en=0.

Test Plan:
- Reset: hold i_rst_n=0 with i_wr_valid=1 → no SRAM enable, all outputs 0. Release → first accept on the next edge.
- Aligned word: write 0xDEADBEEF at 0x10 (width 4, mem_we=4'b1111, addr 4). Then read 0x10 → o_rd_valid exactly 2 cycles after accept with 0xDEADBEEF; o_wr_ready is a single pulse.
- Byte/half writes: word 0x20 preset to 0x00000000. Write byte 0xAA at 0x21 (we=4'b0010), then half 0x1234 at 0x22 (we=4'b1100) → read 0x20 returns 0x1234AA00.
- Split read: words 4=0x44332211 and 8=0x88776655, read 0x06 → two SRAM reads (addr 1, 2), o_rd_data=0x66554433, valid 3 cycles after accept.
- Split write: write 0xCAFEBABE width 4 at 0x0B → cycle0 addr 2 we=4'b1000 wdata[31:24]=0xBE; cycle1 addr 3 we=4'b0111 wdata[23:0]=0xCAFEBA; o_wr_ready the following cycle.
- Faults:
  - Read at byte address 4*MEM_WORDS → no o_mem_en; o_rd_valid with o_fault=1 and data 0.
  - Write width 3'b011 → no write; o_wr_ready with o_fault=1.
  - Hold i_rd_ready low in RD_RESP → valid and data stay stable.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Core-side request/response bus of the memory controller.
// The core is the master; the controller is the slave.
interface mem_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           i_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_wr_valid;
  logic                  o_wr_ready;
  logic [2:0]            i_wr_width;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;
  logic                  i_rd_ready;
  logic                  o_fault;

  modport master (
    output i_addr, i_wr_data, i_wr_valid, i_wr_width, i_rd_ready,
    input  o_wr_ready, o_rd_data, o_rd_valid, o_fault
  );

  modport slave (
    input  i_addr, i_wr_data, i_wr_valid, i_wr_width, i_rd_ready,
    output o_wr_ready, o_rd_data, o_rd_valid, o_fault
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-request memory controller in front of a 1-cycle-latency SRAM.
// Unaligned accesses that straddle a word boundary become two word accesses.
// Out-of-range addresses and illegal write widths produce a faulted response
// without touching the SRAM.
module mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  mem_ctrl_if.slave                    bus,
  output logic                         o_mem_en,
  output logic [DATA_WIDTH/8-1:0]      o_mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]        o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]        i_mem_rdata
);
  localparam int          ADDR_W  = $clog2(MEM_WORDS);
  localparam logic [31:0] WORDS_L = 32'(MEM_WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_A    = 3'd1;
  localparam logic [2:0] S_RD_B    = 3'd2;
  localparam logic [2:0] S_RD_RESP = 3'd3;
  localparam logic [2:0] S_WR_B    = 3'd4;
  localparam logic [2:0] S_WR_ACK  = 3'd5;

  // Byte-lane mask of a write, shifted to its lane; [3:0] hits word A, [7:4] word A+1.
  function automatic logic [7:0] lane_mask(input logic [2:0] width, input logic [1:0] off);
    logic [3:0] m;
    case (width)
      3'b001:  m = 4'b0001;
      3'b010:  m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return {4'b0000, m} << off;
  endfunction

  // Write data shifted to its lane; [31:0] goes to word A, [63:32] to word A+1.
  function automatic logic [63:0] lane_data(input logic [31:0] d, input logic [1:0] off);
    return {32'h0000_0000, d} << {off, 3'b000};
  endfunction

  function automatic logic width_legal(input logic [2:0] w);
    return (w == 3'b001) || (w == 3'b010) || (w == 3'b100);
  endfunction

  // Four bytes starting at off from {word A+1 (low 3 bytes), word A}.
  function automatic logic [31:0] merge_bytes(input logic [55:0] pair, input logic [1:0] off);
    case (off)
      2'd0:    return pair[31:0];
      2'd1:    return pair[39:8];
      2'd2:    return pair[47:16];
      default: return pair[55:24];
    endcase
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        width_q, width_d;
  logic              split_q, split_d;
  logic              fault_q, fault_d;
  logic [31:0]       word0_q, word0_d;
  logic [23:0]       word1_q, word1_d;

  logic              acc_wr_s, acc_rd_s, acc_split_s, acc_fault_s;
  logic [2:0]        acc_size_s;
  logic [31:0]       word_a_s, word_b_s;
  logic [ADDR_W-1:0] lat_word_b_s;
  logic [2:0]        sel_width_s;
  logic [1:0]        sel_off_s;
  logic [31:0]       sel_data_s;
  logic [7:0]        lane_s;
  logic [63:0]       data_s;

  // Decode an incoming request in IDLE: direction, span and fault; reset blocks acceptance.
  always_comb begin
    acc_wr_s    = (state_q == S_IDLE) && i_rst_n && bus.i_wr_valid;
    acc_rd_s    = (state_q == S_IDLE) && i_rst_n && !bus.i_wr_valid && bus.i_rd_ready;
    acc_size_s  = bus.i_wr_valid ? bus.i_wr_width : 3'd4;
    word_a_s    = {2'b00, bus.i_addr[31:2]};
    word_b_s    = word_a_s + 32'd1;
    acc_split_s = ({2'b00, bus.i_addr[1:0]} + {1'b0, acc_size_s}) > 4'd4;
    acc_fault_s = (word_a_s >= WORDS_L)
               || (acc_split_s && (word_b_s >= WORDS_L))
               || (bus.i_wr_valid && !width_legal(bus.i_wr_width));
  end

  // Lane steering: incoming request in IDLE, latched request for the second half.
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_width_s = bus.i_wr_width;
      sel_off_s   = bus.i_addr[1:0];
      sel_data_s  = bus.i_wr_data;
    end else begin
      sel_width_s = width_q;
      sel_off_s   = addr_q[1:0];
      sel_data_s  = wdata_q;
    end
    lane_s       = lane_mask(sel_width_s, sel_off_s);
    data_s       = lane_data(sel_data_s, sel_off_s);
    lat_word_b_s = addr_q[ADDR_W+1:2] + ADDR_W'(1);
  end

  // Next-state and request-latch logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    split_d = split_q;
    fault_d = fault_q;
    word0_d = word0_q;
    word1_d = word1_q;
    case (state_q)
      S_IDLE: begin
        if (acc_wr_s || acc_rd_s) begin
          addr_d  = bus.i_addr[ADDR_W+1:0];
          wdata_d = bus.i_wr_data;
          width_d = bus.i_wr_width;
          split_d = acc_split_s;
          fault_d = acc_fault_s;
          word0_d = 32'h0000_0000;
          word1_d = 24'h00_0000;
          if (acc_wr_s) begin
            state_d = (acc_split_s && !acc_fault_s) ? S_WR_B : S_WR_ACK;
          end else begin
            state_d = acc_fault_s ? S_RD_RESP : S_RD_A;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_A: begin
        word0_d = i_mem_rdata;
        state_d = split_q ? S_RD_B : S_RD_RESP;
      end
      S_RD_B: begin
        word1_d = i_mem_rdata[23:0];
        state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (bus.i_rd_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_RESP;
        end
      end
      S_WR_B:   state_d = S_WR_ACK;
      S_WR_ACK: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // SRAM port: first word on accept, second word from RD_A (read) or WR_B (write).
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 4'b0000;
    o_mem_addr  = '0;
    o_mem_wdata = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        if ((acc_wr_s || acc_rd_s) && !acc_fault_s) begin
          o_mem_en   = 1'b1;
          o_mem_addr = bus.i_addr[ADDR_W+1:2];
          if (acc_wr_s) begin
            o_mem_we    = lane_s[3:0];
            o_mem_wdata = data_s[31:0];
          end else begin
            o_mem_we    = 4'b0000;
            o_mem_wdata = 32'h0000_0000;
          end
        end else begin
          o_mem_en = 1'b0;
        end
      end
      S_RD_A: begin
        if (split_q) begin
          o_mem_en   = 1'b1;
          o_mem_addr = lat_word_b_s;
        end else begin
          o_mem_en = 1'b0;
        end
      end
      S_WR_B: begin
        o_mem_en    = 1'b1;
        o_mem_addr  = lat_word_b_s;
        o_mem_we    = lane_s[7:4];
        o_mem_wdata = data_s[63:32];
      end
      default: o_mem_en = 1'b0;
    endcase
  end

  // Response outputs decoded from state; read data zero unless a good read is presented.
  always_comb begin
    bus.o_rd_valid = (state_q == S_RD_RESP);
    bus.o_wr_ready = (state_q == S_WR_ACK);
    bus.o_fault    = fault_q && ((state_q == S_RD_RESP) || (state_q == S_WR_ACK));
    if ((state_q == S_RD_RESP) && !fault_q) begin
      bus.o_rd_data = merge_bytes({word1_q, word0_q}, addr_q[1:0]);
    end else begin
      bus.o_rd_data = 32'h0000_0000;
    end
  end

  // State and latched request; reset abandons any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      width_q <= 3'b000;
      split_q <= 1'b0;
      fault_q <= 1'b0;
      word0_q <= 32'h0000_0000;
      word1_q <= 24'h00_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      split_q <= split_d;
      fault_q <= fault_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
    end
  end
endmodule
